// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the counter top-level and its command dispatcher.
//   - DEF_CNT_WIDTH : default width of a count value, shared with the counter
//   - state_t       : dispatcher FSM state encoding
//                     (S_IDLE=0, S_START=1, S_WAIT=2)
// ---------------------------------------------------------------------------
package cnt_pkg;

    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cnt_cmd_fifo
// Synchronous FIFO of DEPTH entries, WIDTH bits each, that buffers count
// commands ahead of the dispatcher FSM. The head entry is always visible on
// dout while the FIFO is not empty.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (flushes the FIFO)
//   push   in   write din (ignored when full)
//   din    in   WIDTH-bit write data
//   pop    in   drop the head entry (ignored when empty)
//   dout   out  head entry
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  occupancy, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module cnt_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full/empty come only from the registered count, so a pop in the same
    // cycle never makes room for a push while the FIFO is full.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers simply wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array needs no reset; stale entries are never read because
    // empty blocks every pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cnt_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// cnt_cmd_dispatcher
// Upstream command stage for the counter top-level. Count commands arrive on
// a valid/ready interface, are buffered in cnt_cmd_fifo and issued one at a
// time as a one-cycle start pulse plus a held count value. The next command
// is issued only after the counter reports done.
//
// Optional feature (macro CNT_CMD_ZERO_SKIP_EN): a zero-valued head entry is
// retired in S_IDLE without issuing a start pulse; it still counts as a
// completed job and leaves cnt_val_o untouched.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   cmd_valid_i  in   command present
//   cmd_ready_o  out  FIFO can accept (not full)
//   cmd_val_i    in   requested count value
//   cnt_idle_i   in   counter FSM idle
//   cnt_done_i   in   counter FSM done pulse
//   start_o      out  one-cycle start to counter
//   cnt_val_o    out  registered count value to counter
//   busy_o       out  job in flight
//   pending_o    out  FIFO occupancy (excludes the in-flight job)
//   jobs_o       out  completed jobs, wrapping
// ---------------------------------------------------------------------------
module cnt_cmd_dispatcher
    import cnt_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int DEPTH     = 4,
    parameter int JOBS_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [CNT_WIDTH-1:0]     cmd_val_i,
    input  logic                     cnt_idle_i,
    input  logic                     cnt_done_i,
    output logic                     start_o,
    output logic [CNT_WIDTH-1:0]     cnt_val_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [JOBS_W-1:0]        jobs_o
);

    state_t               state;
    state_t               next_state;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_WIDTH-1:0] fifo_head;
    logic                 load_val;
    logic                 job_inc;

    cnt_cmd_fifo #(
        .WIDTH (CNT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid_i),
        .din   (cmd_val_i),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_o)
    );

    assign cmd_ready_o = !fifo_full;
    assign busy_o      = (state != S_IDLE);
    // Gated with rst so a reset landing on the S_START cycle issues no pulse.
    assign start_o     = (state == S_START) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. The only pop happens on leaving S_IDLE (or on a
    // skipped zero entry), and done is honoured only in S_WAIT.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        load_val   = 1'b0;
        job_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
`ifdef CNT_CMD_ZERO_SKIP_EN
                    if (fifo_head == '0) begin
                        fifo_pop = 1'b1;
                        job_inc  = 1'b1;
                    end else
`endif
                    if (cnt_idle_i) begin
                        fifo_pop   = 1'b1;
                        load_val   = 1'b1;
                        next_state = S_START;
                    end
                end
            end
            S_START: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_done_i) begin
                    next_state = S_IDLE;
                    job_inc    = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Count value is captured at the pop and held until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_val_o <= '0;
        end else if (load_val) begin
            cnt_val_o <= fifo_head;
        end
    end

    // Completed-job counter, wrapping naturally at 2^JOBS_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_o <= '0;
        end else if (job_inc) begin
            jobs_o <= jobs_o + JOBS_W'(1);
        end
    end

endmodule

// File: tb/tb_cnt_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_cnt_cmd_dispatcher
// Directed self-checking bench for cnt_cmd_dispatcher: reset values, single
// job latency, fill/ordering, simultaneous push+pop, reset mid-operation and
// zero-value handling (both builds of CNT_CMD_ZERO_SKIP_EN).
// ---------------------------------------------------------------------------
module tb_cnt_cmd_dispatcher;

    localparam int CW = 8;
    localparam int D  = 4;
    localparam int JW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_val = '0;
    logic          cnt_idle = 1'b0;
    logic          cnt_done = 1'b0;
    logic          start;
    logic [CW-1:0] cnt_val;
    logic          busy;
    logic [$clog2(D):0] pending;
    logic [JW-1:0] jobs;

    int vec_count = 0;
    int err_count = 0;

    cnt_cmd_dispatcher #(
        .CNT_WIDTH (CW),
        .DEPTH     (D),
        .JOBS_W    (JW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_val_i   (cmd_val),
        .cnt_idle_i  (cnt_idle),
        .cnt_done_i  (cnt_done),
        .start_o     (start),
        .cnt_val_o   (cnt_val),
        .busy_o      (busy),
        .pending_o   (pending),
        .jobs_o      (jobs)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive all data inputs in one go.
    task automatic applyStimulus(input logic valid, input logic [CW-1:0] val,
                                 input logic idle, input logic done);
        cmd_valid = valid;
        cmd_val   = val;
        cnt_idle  = idle;
        cnt_done  = done;
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CW-1:0] order [4];
        order[0] = 8'd3;
        order[1] = 8'd7;
        order[2] = 8'd9;
        order[3] = 8'd1;

        // Reset values after two reset cycles.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        step(2);
        checkOutput("rst_start",   start,     0);
        checkOutput("rst_cnt_val", cnt_val,   0);
        checkOutput("rst_busy",    busy,      0);
        checkOutput("rst_pending", pending,   0);
        checkOutput("rst_jobs",    jobs,      0);
        checkOutput("rst_ready",   cmd_ready, 1);
        rst = 1'b0;
        step(1);

        // Single job: accept at N, start at N+2, done returns to idle.
        applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("single_pending_n1", pending, 1);
        checkOutput("single_start_n1",   start,   0);
        step(1);
        checkOutput("single_start_n2",   start,   1);
        checkOutput("single_val_n2",     cnt_val, 5);
        checkOutput("single_busy_n2",    busy,    1);
        checkOutput("single_pending_n2", pending, 0);
        step(1);
        checkOutput("single_start_n3",   start,   0);
        checkOutput("single_busy_n3",    busy,    1);
        step(5);
        checkOutput("single_val_hold",   cnt_val, 5);
        checkOutput("single_jobs_wait",  jobs,    0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("single_jobs_done",  jobs,    1);
        checkOutput("single_busy_done",  busy,    0);
        checkOutput("single_val_after",  cnt_val, 5);
        // Done while idle must not count.
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("idle_done_ignored", jobs,    1);

        // Fill with counter busy, refuse a fifth push, then drain in order.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, order[i], 1'b0, 1'b0);
            step(1);
        end
        checkOutput("fill_pending", pending,   4);
        checkOutput("fill_ready",   cmd_ready, 0);
        checkOutput("fill_busy",    busy,      0);
        applyStimulus(1'b1, 8'd55, 1'b0, 1'b0);
        step(1);
        checkOutput("fill_refused", pending,   4);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkOutput("drain_start",   start,   1);
            checkOutput("drain_val",     cnt_val, order[i]);
            checkOutput("drain_pending", pending, 3 - i);
            step(1);
            checkOutput("drain_single_pulse", start, 0);
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            step(1);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("drain_jobs", jobs, 4);
        step(2);
        checkOutput("drain_no_fifth", busy, 0);

        // Push coinciding with a pop at occupancy 2, then reset in S_WAIT.
        doReset();
        applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
        step(1);
        checkOutput("pp_pending_pre", pending, 2);
        applyStimulus(1'b1, 8'd30, 1'b1, 1'b0);
        step(1);
        checkOutput("pp_pending", pending, 2);
        checkOutput("pp_start",   start,   1);
        checkOutput("pp_val",     cnt_val, 10);
        applyStimulus(1'b1, 8'd40, 1'b1, 1'b0);
        step(1);
        checkOutput("mid_pending_pre", pending, 3);
        checkOutput("mid_busy_pre",    busy,    1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("mid_pending", pending,   0);
        checkOutput("mid_busy",    busy,      0);
        checkOutput("mid_ready",   cmd_ready, 1);
        checkOutput("mid_val",     cnt_val,   0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("mid_late_done_jobs", jobs, 0);
        checkOutput("mid_late_done_busy", busy, 0);

        // Reset asserted during the S_START cycle suppresses the pulse.
        applyStimulus(1'b1, 8'd6, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        step(1);
        checkOutput("rst_start_pre", start, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_start_gated", start, 0);
        step(1);
        rst = 1'b0;
        checkOutput("rst_start_busy", busy, 0);

        // Zero-valued command followed by 4.
        doReset();
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b1, 8'd4, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
`ifdef CNT_CMD_ZERO_SKIP_EN
        checkOutput("zero_skip_start",   start,   0);
        checkOutput("zero_skip_jobs",    jobs,    1);
        checkOutput("zero_skip_pending", pending, 1);
        checkOutput("zero_skip_busy",    busy,    0);
        step(1);
        checkOutput("zero_next_start",   start,   1);
        checkOutput("zero_next_val",     cnt_val, 4);
        checkOutput("zero_next_jobs",    jobs,    1);
`else
        checkOutput("zero_issue_start",   start,   1);
        checkOutput("zero_issue_val",     cnt_val, 0);
        checkOutput("zero_issue_pending", pending, 1);
        checkOutput("zero_issue_jobs",    jobs,    0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/cnt_cmd_dispatcher.md
Name: cnt_cmd_dispatcher

Overview:
Upstream command stage for the counter top-level (counter + write FSM with start/cnt_val/idle/done handshake).
- Accepts count-length commands on a valid/ready interface and buffers them in a small FIFO.
- Issues them one at a time as a single-cycle start pulse plus a held count value.
- Waits for the counter's done before issuing the next command, so back-to-back jobs run without software polling.

Parameters:
- CNT_WIDTH, 8, width of count value (matches counter CNT_WIDTH).
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- JOBS_W, 16, width of completed-job counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  FIFO can accept (not full).
- cmd_val_i  in  CNT_WIDTH  requested count value.
- cnt_idle_i  in  1  counter FSM idle.
- cnt_done_i  in  1  counter FSM done pulse.
- start_o  out  1  one-cycle start to counter.
- cnt_val_o  out  CNT_WIDTH  count value to counter; registered.
- busy_o  out  1  job in flight (state != S_IDLE).
- pending_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- jobs_o  out  JOBS_W  completed jobs; wraps modulo 2^JOBS_W.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. All state updates on the rising clk edge.
- Reset values: start_o=0, cnt_val_o=0, busy_o=0, pending_o=0, jobs_o=0, cmd_ready_o=1. FIFO pointers cleared, state S_IDLE.
- Reset mid-operation: the FIFO is flushed and any in-flight job is abandoned; no start pulse is issued in the reset cycle.
- FIFO push and ready:
  - Push when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full, derived from registered count only. A pop in the same cycle does not open a slot when full.
- FIFO pop: only in the S_IDLE->S_START transition; never pops when empty.
- Simultaneous push+pop: occupancy unchanged. Order is strict FIFO.
- FSM:
  - S_IDLE: if !empty && cnt_idle_i, pop head into cnt_val_o and go to S_START; else stay.
  - S_START: start_o=1 for exactly this cycle; next state is S_WAIT.
  - S_WAIT: hold cnt_val_o stable. On cnt_done_i go to S_IDLE and increment jobs_o.
- Latency: command accepted at cycle N with FIFO empty and counter idle -> start_o high at cycle N+2.
- Issue gap: minimum 1 cycle in S_IDLE between done and the next start_o.
- cnt_done_i in S_IDLE or S_START is ignored and does not count.
- cnt_idle_i low in S_IDLE blocks issue indefinitely; commands keep buffering until full.
- cnt_val_o holds its last issued value until the next pop.
- pending_o excludes the in-flight job.

Optional Feature:
- Macro: CNT_CMD_ZERO_SKIP_EN.
- Defined: a head entry with value 0 is popped in S_IDLE without issuing start_o, regardless of cnt_idle_i. It increments jobs_o and stays in S_IDLE; the next entry is eligible the following cycle. cnt_val_o is not updated.
- Undefined: zero values are issued like any other command.

Decomposition:
- Shared package cnt_pkg: state encoding localparams (S_IDLE=2'd0, S_START=2'd1, S_WAIT=2'd2) and the default CNT_WIDTH constant shared with the counter top.
- One sub-module: cnt_cmd_fifo (sync FIFO, DEPTH x CNT_WIDTH, push/pop/full/empty/count).
- FSM and jobs counter stay in cnt_cmd_dispatcher.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs at reset values, cmd_ready_o=1.
- Single job: push 8'd5 at cycle 10 with cnt_idle_i=1 -> start_o=1 at cycle 12 only, cnt_val_o=5. Done at cycle 20 -> jobs_o=1, busy_o=0 at cycle 21.
- Fill and ordering: hold cnt_idle_i=0 and push 4 values (3,7,9,1) -> pending_o=4, cmd_ready_o=0, fifth push refused. Then release and pulse done per job -> issued in order 3,7,9,1, jobs_o=4.
- Simultaneous push+pop: push while FSM pops at occupancy 2 -> pending_o stays 2.
- Reset mid-operation: rst in S_WAIT with pending_o=3 -> pending_o=0, busy_o=0. A later done is ignored and jobs_o stays 0.
- CNT_CMD_ZERO_SKIP_EN: push 0 then 4 -> no start for 0, jobs_o=1, start_o with cnt_val_o=4 next. Without the macro, start_o is issued with cnt_val_o=0.
